// File: rtl/ahb_apb_pkg.sv
// Shared types for the AHB-Lite to APB bridge.
// AHB_APB_ALIGN_ERR_EN adds the two error-response states for misaligned requests.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

`ifdef AHB_APB_ALIGN_ERR_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS
  } bridge_state_t;
`endif

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: each AHB transfer becomes one APB SETUP+ACCESS pair.
// Optional AHB_APB_ALIGN_ERR_EN: misaligned requests get a two-cycle ERROR instead of an APB access.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HREADY_IN,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HRESP,
  output logic                  HREADY_OUT,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA
);

  bridge_state_t         state, state_nxt;
  logic [DATA_WIDTH-1:0] hrdata_nxt;
  logic                  hresp_nxt;
  logic                  hready_nxt;
  logic                  psel_nxt;
  logic                  penable_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic                  pwrite_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt;
  logic                  req_vld;

  // HREADY_OUT is only high in IDLE/ERR2, so it also gates acceptance to the idle window
  assign req_vld = HSEL & HTRANS[1] & HREADY_IN & HREADY_OUT;

  always_comb begin
    state_nxt   = state;
    hrdata_nxt  = HRDATA;
    hresp_nxt   = HRESP;
    hready_nxt  = HREADY_OUT;
    psel_nxt    = PSEL;
    penable_nxt = PENABLE;
    paddr_nxt   = PADDR;
    pwrite_nxt  = PWRITE;
    pwdata_nxt  = PWDATA;
    case (state)
      ST_IDLE: begin
        if (req_vld) begin
`ifdef AHB_APB_ALIGN_ERR_EN
          if (HADDR[1:0] != 2'b00) begin
            state_nxt  = ST_ERR1;
            hresp_nxt  = HRESP_ERROR;
            hready_nxt = 1'b0;
          end else begin
`else
          begin
`endif
            state_nxt  = ST_LATCH;
            paddr_nxt  = HADDR;
            pwrite_nxt = HWRITE;
            hready_nxt = 1'b0;
          end
        end
      end
      ST_LATCH: begin
        // HWDATA is valid only now, one cycle after the address phase
        if (PWRITE) pwdata_nxt = HWDATA;
        psel_nxt  = 1'b1;
        state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!PWRITE) hrdata_nxt = PRDATA;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        hready_nxt  = 1'b1;
        state_nxt   = ST_IDLE;
      end
`ifdef AHB_APB_ALIGN_ERR_EN
      ST_ERR1: begin
        hready_nxt = 1'b1;
        state_nxt  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_nxt = HRESP_OKAY;
        state_nxt = ST_IDLE;
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      HRDATA     <= '0;
      HRESP      <= HRESP_OKAY;
      HREADY_OUT <= 1'b1;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
    end else begin
      state      <= state_nxt;
      HRDATA     <= hrdata_nxt;
      HRESP      <= hresp_nxt;
      HREADY_OUT <= hready_nxt;
      PSEL       <= psel_nxt;
      PENABLE    <= penable_nxt;
      PADDR      <= paddr_nxt;
      PWRITE     <= pwrite_nxt;
      PWDATA     <= pwdata_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: directed AHB scenarios plus randomized traffic against a cycle-level model.
module tb_ahb_apb_bridge;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY_IN;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADY_OUT;
  logic [31:0] PRDATA;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;

  ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY_IN(HREADY_IN), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HRESP(HRESP), .HREADY_OUT(HREADY_OUT), .PRDATA(PRDATA), .PSEL(PSEL),
    .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // APB peripheral: simple memory, read-before-write returns zero
  logic [31:0] apb_mem [logic [31:0]];
  logic [31:0] apb_wr_q [$];

  initial forever begin
    @(posedge HCLK);
    if (PSEL === 1'b1 && PENABLE === 1'b1 && PWRITE === 1'b1) begin
      apb_mem[PADDR] = PWDATA;
      apb_wr_q.push_back(PADDR);
    end
  end

  initial begin
    PRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      if (PSEL === 1'b1) PRDATA = apb_mem.exists(PADDR) ? apb_mem[PADDR] : 32'h0;
      else PRDATA = $urandom;
    end
  end

  // Reference model: transfer timeline counted in cycles since acceptance, memory as a scoreboard
  logic [31:0] exp_hrdata, exp_paddr, exp_pwdata;
  logic        exp_hresp, exp_hready, exp_psel, exp_penable, exp_pwrite;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] cur_addr;
  logic        cur_write;
  int          k = 0;
  int          ek = 0;
  int          exp_xfers = 0;
  bit          model_ok = 0;

  task automatic model_step();
    if (HRESET === 1'b1) begin
      exp_hrdata = 0; exp_paddr = 0; exp_pwdata = 0; exp_hresp = 0; exp_hready = 1;
      exp_psel = 0; exp_penable = 0; exp_pwrite = 0; k = 0; ek = 0; model_ok = 1;
      return;
    end
    if (!model_ok) return;
    if (ek == 1) begin
      exp_hready = 1; ek = 2;
    end else if (ek == 2) begin
      exp_hresp = 0; ek = 0;
    end else begin
      case (k)
        0: if (HSEL && HTRANS[1] && HREADY_IN && exp_hready) begin
`ifdef AHB_APB_ALIGN_ERR_EN
          if (HADDR[1:0] != 2'b00) begin
            ek = 1; exp_hresp = 1; exp_hready = 0;
          end else begin
`else
          begin
`endif
            k = 1; cur_addr = HADDR; cur_write = HWRITE;
            exp_paddr = HADDR; exp_pwrite = HWRITE; exp_hready = 0; exp_xfers++;
          end
        end
        1: begin
          if (cur_write) begin exp_pwdata = HWDATA; mem_model[cur_addr] = HWDATA; end
          exp_psel = 1; k = 2;
        end
        2: begin exp_penable = 1; k = 3; end
        default: begin
          exp_psel = 0; exp_penable = 0; exp_hready = 1; k = 0;
          if (!cur_write) exp_hrdata = mem_model.exists(cur_addr) ? mem_model[cur_addr] : 32'h0;
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge HCLK);
    model_step();
  end

  int psel_only_cnt = 0;
  int access_cnt    = 0;
  int access_total  = 0;
  int hrlow_cnt     = 0;

  initial forever begin
    @(negedge HCLK);
    if (model_ok) begin
      chk("cyc_HREADY_OUT", {31'b0, HREADY_OUT}, {31'b0, exp_hready});
      chk("cyc_HRESP",      {31'b0, HRESP},      {31'b0, exp_hresp});
      chk("cyc_PSEL",       {31'b0, PSEL},       {31'b0, exp_psel});
      chk("cyc_PENABLE",    {31'b0, PENABLE},    {31'b0, exp_penable});
      chk("cyc_PADDR",      PADDR,               exp_paddr);
      chk("cyc_PWRITE",     {31'b0, PWRITE},     {31'b0, exp_pwrite});
      chk("cyc_PWDATA",     PWDATA,              exp_pwdata);
      chk("cyc_HRDATA",     HRDATA,              exp_hrdata);
      if (PSEL === 1'b1 && PENABLE === 1'b0) psel_only_cnt++;
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin access_cnt++; access_total++; end
      if (HREADY_OUT === 1'b0) hrlow_cnt++;
    end
  end

  // AHB master
  logic [31:0] t_addr [16];
  logic        t_write [16];
  logic [31:0] t_data [16];
  logic [31:0] t_rdata [16];
  int          t_n = 0;
  int          gap_max = 0;

  task automatic idle_inputs();
    HSEL = 0; HTRANS = 2'b00; HREADY_IN = 1; HWRITE = 0; HADDR = 32'h0;
  endtask

  task automatic garbage();
    case ($urandom_range(0, 2))
      0: begin HSEL = 0; HTRANS = 2'($urandom_range(0, 3)); HREADY_IN = 1; end
      1: begin HSEL = 1; HTRANS = 2'($urandom_range(0, 1)); HREADY_IN = 1; end
      default: begin HSEL = 1; HTRANS = 2'($urandom_range(2, 3)); HREADY_IN = 0; end
    endcase
    HADDR = $urandom; HWRITE = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_accept();
    int g = 0;
    while (HREADY_OUT !== 1'b1 && g < 20) begin @(posedge HCLK); #1; g++; end
    if (HREADY_OUT !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: HREADY_OUT %b required 1", HREADY_OUT);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic run_xfers();
    for (int i = 0; i <= t_n; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin garbage(); @(posedge HCLK); #1; end
      if (i < t_n) begin
        HSEL = 1; HTRANS = 2'b10; HADDR = t_addr[i]; HWRITE = t_write[i]; HREADY_IN = 1;
      end else idle_inputs();
      wait_accept();
      if (i > 0) t_rdata[i-1] = HRDATA;
      if (i < t_n) HWDATA = t_write[i] ? t_data[i] : $urandom;
    end
  endtask

  task automatic set_x(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    t_addr[i] = a; t_write[i] = w; t_data[i] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    HRESET = 1; HWDATA = 0; idle_inputs();
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_HREADY_OUT", {31'b0, HREADY_OUT}, 32'd1);
    chk("rst_PSEL", {31'b0, PSEL}, 32'd0);
    chk("rst_PADDR", PADDR, 32'h0);
    chk("rst_HRDATA", HRDATA, 32'h0);
    HRESET = 0;
    repeat (2) @(posedge HCLK);
    #1;

    // 1: write then read 0x04
    psel_only_cnt = 0; access_cnt = 0; gap_max = 0;
    t_n = 1; set_x(0, 32'h04, 1, 32'hBEEFBEEF); run_xfers();
    chk("t1_setup_cycles", psel_only_cnt, 1);
    chk("t1_access_cycles", access_cnt, 1);
    chk("t1_PWDATA", PWDATA, 32'hBEEFBEEF);
    chk("t1_PADDR", PADDR, 32'h04);
    t_n = 1; set_x(0, 32'h04, 0, 32'h0); run_xfers();
    chk("t1_HRDATA", t_rdata[0], 32'hBEEFBEEF);
    chk("t1_HRESP", {31'b0, HRESP}, 32'd0);

    // 2: four writes then four reads, back to back
    t_n = 8;
    for (int i = 0; i < 4; i++) begin
      set_x(i, 32'h20 + 32'(4 * i), 1, 32'h10000000 + 32'(i));
      set_x(i + 4, 32'h20 + 32'(4 * i), 0, 32'h0);
    end
    hrlow_cnt = 0;
    run_xfers();
    chk("t2_hready_low_cycles", hrlow_cnt, 24);
    for (int i = 0; i < 4; i++) chk("t2_readback", t_rdata[i + 4], 32'h10000000 + 32'(i));

    // 3: unselected or IDLE requests
    psel_only_cnt = 0; access_cnt = 0; hrlow_cnt = 0;
    HWDATA = 32'h55555555;
    for (int i = 0; i < 8; i++) begin
      HSEL = (i >= 4); HTRANS = (i >= 4) ? 2'b00 : 2'b10;
      HWRITE = 1; HADDR = 32'h40; HREADY_IN = 1;
      @(posedge HCLK); #1;
    end
    idle_inputs();
    @(posedge HCLK); #1;
    chk("t3_psel_cycles", psel_only_cnt + access_cnt, 0);
    chk("t3_hready_low_cycles", hrlow_cnt, 0);

    // 4: pipelined writes with second address held during stall
    apb_wr_q.delete();
    access_cnt = 0;
    t_n = 4;
    set_x(0, 32'h10, 1, 32'h1234); set_x(1, 32'h14, 1, 32'h4321);
    set_x(2, 32'h10, 0, 32'h0);    set_x(3, 32'h14, 0, 32'h0);
    run_xfers();
    chk("t4_apb_writes", apb_wr_q.size(), 2);
    if (apb_wr_q.size() == 2) begin
      chk("t4_first_write_addr", apb_wr_q[0], 32'h10);
      chk("t4_second_write_addr", apb_wr_q[1], 32'h14);
    end
    chk("t4_access_cycles", access_cnt, 4);
    chk("t4_read0", t_rdata[2], 32'h1234);
    chk("t4_read1", t_rdata[3], 32'h4321);

    // 5: reset during ACCESS
    HSEL = 1; HTRANS = 2'b10; HADDR = 32'h60; HWRITE = 1; HREADY_IN = 1;
    wait_accept();
    HWDATA = 32'h12345678; idle_inputs();
    g = 0;
    while (!(PSEL === 1'b1 && PENABLE === 1'b1) && g < 10) begin @(posedge HCLK); #1; g++; end
    chk("t5_reached_access", {31'b0, (PSEL === 1'b1 && PENABLE === 1'b1)}, 32'd1);
    HRESET = 1;
    @(posedge HCLK); #1;
    chk("t5_PSEL", {31'b0, PSEL}, 32'd0);
    chk("t5_PENABLE", {31'b0, PENABLE}, 32'd0);
    chk("t5_PADDR", PADDR, 32'h0);
    chk("t5_PWRITE", {31'b0, PWRITE}, 32'd0);
    chk("t5_PWDATA", PWDATA, 32'h0);
    chk("t5_HRDATA", HRDATA, 32'h0);
    chk("t5_HRESP", {31'b0, HRESP}, 32'd0);
    chk("t5_HREADY_OUT", {31'b0, HREADY_OUT}, 32'd1);
    HRESET = 0;
    t_n = 2; set_x(0, 32'h50, 1, 32'hCAFEBEEF); set_x(1, 32'h50, 0, 32'h0);
    run_xfers();
    chk("t5_readback", t_rdata[1], 32'hCAFEBEEF);

`ifdef AHB_APB_ALIGN_ERR_EN
    // 6: misaligned write gets ERROR and no APB access
    psel_only_cnt = 0; access_cnt = 0;
    HSEL = 1; HTRANS = 2'b10; HADDR = 32'h03; HWRITE = 1; HREADY_IN = 1;
    wait_accept();
    HWDATA = 32'h0BAD0BAD; idle_inputs();
    chk("t6_err1_HRESP", {31'b0, HRESP}, 32'd1);
    chk("t6_err1_HREADY", {31'b0, HREADY_OUT}, 32'd0);
    @(posedge HCLK); #1;
    chk("t6_err2_HRESP", {31'b0, HRESP}, 32'd1);
    chk("t6_err2_HREADY", {31'b0, HREADY_OUT}, 32'd1);
    @(posedge HCLK); #1;
    chk("t6_after_HRESP", {31'b0, HRESP}, 32'd0);
    chk("t6_psel_cycles", psel_only_cnt + access_cnt, 0);
    chk("t6_mem_untouched", {31'b0, apb_mem.exists(32'h03)}, 32'd0);
`endif

    // randomized traffic with idle/BUSY/unselected gaps
    for (int b = 0; b < 40; b++) begin
      t_n = 8;
      for (int i = 0; i < 8; i++) begin
        t_addr[i] = 32'h80 + 32'(4 * $urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) t_addr[i][1:0] = 2'($urandom_range(1, 3));
        t_write[i] = 1'($urandom_range(0, 1));
        t_data[i] = $urandom;
      end
      gap_max = 2;
      run_xfers();
    end
    repeat (4) @(posedge HCLK);
    #1;
    chk("total_apb_accesses", access_total, exp_xfers);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
